// File: rtl/mc_alu_ctrl.sv
// -----------------------------------------------------------------------------
// mc_alu_ctrl
//   Multi-cycle MIPS control FSM. Decodes the held instruction register and
//   steps each instruction through fetch, decode, execute, memory and
//   writeback, driving the ALU function/operand selects, all datapath write
//   enables and memory strobes, and counting retired instructions.
//
// Ports:
//   i_clk, i_rst    clock; synchronous active-high reset
//   i_instr         instruction register contents (stable from DECODE on)
//   i_mem_ready     memory acknowledge for the current read/write
//   i_zero          ALU zero flag, same cycle as o_func
//   o_func          ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT
//   o_srca_sel      ALU A: 0 PC, 1 rs
//   o_srcb_sel      ALU B: 00 rt, 01 const 4, 10 sext imm, 11 sext imm<<2
//   o_iord          memory address: 0 PC, 1 ALUOut
//   o_mem_re/we     memory read / write strobes
//   o_ir_we, o_pc_we, o_reg_we   datapath write enables
//   o_pc_src        PC source: 00 ALU result, 01 ALUOut, 10 jump target
//   o_reg_dst       destination: 0 rt, 1 rd
//   o_mem_to_reg    writeback data: 0 ALUOut, 1 memory data
//   o_illegal       one-cycle pulse on an unsupported instruction
//   o_state         current state encoding (debug)
//   o_retired       completed-instruction counter, wraps
// -----------------------------------------------------------------------------
module mc_alu_ctrl #(
    parameter int FUNC_SIZE = 11,
    parameter int CNT_SIZE  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [31:0]          i_instr,
    input  logic                 i_mem_ready,
    input  logic                 i_zero,
    output logic [FUNC_SIZE-1:0] o_func,
    output logic                 o_srca_sel,
    output logic [1:0]           o_srcb_sel,
    output logic                 o_iord,
    output logic                 o_mem_re,
    output logic                 o_mem_we,
    output logic                 o_ir_we,
    output logic                 o_pc_we,
    output logic [1:0]           o_pc_src,
    output logic                 o_reg_we,
    output logic                 o_reg_dst,
    output logic                 o_mem_to_reg,
    output logic                 o_illegal,
    output logic [3:0]           o_state,
    output logic [CNT_SIZE-1:0]  o_retired
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEXE   = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEXE = 4'd9,
        S_JUMP    = 4'd10,
        S_ILLEGAL = 4'd11,
        S_ADDIWB  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;

    state_t              state;
    state_t              next_state;
    logic [CNT_SIZE-1:0] retired;
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [2:0]          rtype_op;
    logic                funct_ok;
    logic [2:0]          alu_op;
    logic                retire;
    logic                unused_instr_bits;

    assign opcode            = i_instr[31:26];
    assign funct             = i_instr[5:0];
    assign unused_instr_bits = ^i_instr[25:6];

    // R-type funct field to ALU op; unsupported functs are flagged.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        rtype_op = ALU_ADD;
        funct_ok = 1'b1;
        case (funct)
            6'h20:   rtype_op = 3'd0;
            6'h22:   rtype_op = 3'd1;
            6'h24:   rtype_op = 3'd2;
            6'h25:   rtype_op = 3'd3;
            6'h26:   rtype_op = 3'd4;
            6'h2A:   rtype_op = 3'd5;
            default: funct_ok = 1'b0;
        endcase
    end

    // State register and retired counter. Reset abandons the in-flight
    // instruction without counting it.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (i_rst) begin
            state   <= S_FETCH;
            retired <= '0;
        end else begin
            state <= next_state;
            if (retire) retired <= retired + CNT_SIZE'(1);
        end
    end

    // An instruction completes on the transition back to FETCH from any
    // terminal state; ILLEGAL is deliberately absent.
    assign retire = (next_state == S_FETCH) &&
                    (state inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH,
                                   S_ADDIWB, S_JUMP});

    // Next-state and per-state datapath controls.
    always_comb begin
        next_state   = S_FETCH;
        alu_op       = ALU_ADD;
        o_srca_sel   = 1'b0;
        o_srcb_sel   = 2'b00;
        o_iord       = 1'b0;
        o_mem_re     = 1'b0;
        o_mem_we     = 1'b0;
        o_ir_we      = 1'b0;
        o_pc_we      = 1'b0;
        o_pc_src     = 2'b00;
        o_reg_we     = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                o_mem_re   = 1'b1;
                o_srcb_sel = 2'b01;
                // IR and PC load in the acknowledge cycle itself (PC+4).
                o_ir_we    = i_mem_ready;
                o_pc_we    = i_mem_ready;
                next_state = i_mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                o_srcb_sel = 2'b11;
                case (opcode)
                    OP_RTYPE:     next_state = funct_ok ? S_RTEXE : S_ILLEGAL;
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEXE;
                    OP_J:         next_state = S_JUMP;
                    default:      next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                o_srca_sel = 1'b1;
                o_srcb_sel = 2'b10;
                next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                o_iord     = 1'b1;
                o_mem_re   = 1'b1;
                next_state = i_mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                o_reg_we     = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                o_iord     = 1'b1;
                o_mem_we   = 1'b1;
                next_state = i_mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTEXE: begin
                o_srca_sel = 1'b1;
                alu_op     = rtype_op;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                o_reg_we  = 1'b1;
                o_reg_dst = 1'b1;
            end
            S_BRANCH: begin
                o_srca_sel = 1'b1;
                alu_op     = ALU_SUB;
                o_pc_src   = 2'b01;
                o_pc_we    = i_zero;
            end
            S_ADDIEXE: begin
                o_srca_sel = 1'b1;
                o_srcb_sel = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: o_reg_we = 1'b1;
            S_JUMP: begin
                o_pc_src = 2'b10;
                o_pc_we  = 1'b1;
            end
            S_ILLEGAL: o_illegal = 1'b1;
            default:   next_state = S_FETCH;
        endcase

        // Nothing may write or strobe memory during the reset cycle.
        if (i_rst) begin
            o_mem_we  = 1'b0;
            o_ir_we   = 1'b0;
            o_pc_we   = 1'b0;
            o_reg_we  = 1'b0;
            o_mem_re  = 1'b0;
            o_illegal = 1'b0;
        end
    end

    assign o_func    = FUNC_SIZE'(alu_op);
    assign o_state   = state;
    assign o_retired = retired;

endmodule

// File: tb/tb_mc_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_alu_ctrl
//   Scoreboard bench for mc_alu_ctrl. For each instruction the stimulus side
//   derives the expected cycle-by-cycle control trace from the instruction
//   word and the memory-wait pattern, queues it, then drives the inputs. A
//   monitor pops one expectation per cycle and compares. A second instance
//   with CNT_SIZE = 4 shares the stimulus to exercise counter wrap.
// -----------------------------------------------------------------------------
module tb_mc_alu_ctrl;

    typedef struct packed {
        logic [3:0]  state;
        logic [10:0] func;
        logic        srca;
        logic [1:0]  srcb;
        logic        iord;
        logic        mem_re;
        logic        mem_we;
        logic        ir_we;
        logic        pc_we;
        logic [1:0]  pc_src;
        logic        reg_we;
        logic        reg_dst;
        logic        mem_to_reg;
        logic        illegal;
    } ctl_t;

    typedef struct {
        ctl_t        ctl;
        logic        rst;
        logic        rdy;
        logic        zero;
        int unsigned retired;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        mem_ready = 1'b1;
    logic        zero = 1'b0;

    logic [10:0] a_func, b_func;
    logic        a_srca, b_srca, a_iord, b_iord, a_mem_re, b_mem_re;
    logic        a_mem_we, b_mem_we, a_ir_we, b_ir_we, a_pc_we, b_pc_we;
    logic [1:0]  a_srcb, b_srcb, a_pc_src, b_pc_src;
    logic        a_reg_we, b_reg_we, a_reg_dst, b_reg_dst;
    logic        a_m2r, b_m2r, a_illegal, b_illegal;
    logic [3:0]  a_state, b_state;
    logic [31:0] a_retired;
    logic [3:0]  b_retired;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned model_ret = 0;
    cyc_t        exp_q[$];
    cyc_t        trace[$];

    always #5 clk = ~clk;

    mc_alu_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_mem_ready(mem_ready),
        .i_zero(zero), .o_func(a_func), .o_srca_sel(a_srca),
        .o_srcb_sel(a_srcb), .o_iord(a_iord), .o_mem_re(a_mem_re),
        .o_mem_we(a_mem_we), .o_ir_we(a_ir_we), .o_pc_we(a_pc_we),
        .o_pc_src(a_pc_src), .o_reg_we(a_reg_we), .o_reg_dst(a_reg_dst),
        .o_mem_to_reg(a_m2r), .o_illegal(a_illegal), .o_state(a_state),
        .o_retired(a_retired)
    );

    mc_alu_ctrl #(.CNT_SIZE(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_mem_ready(mem_ready),
        .i_zero(zero), .o_func(b_func), .o_srca_sel(b_srca),
        .o_srcb_sel(b_srcb), .o_iord(b_iord), .o_mem_re(b_mem_re),
        .o_mem_we(b_mem_we), .o_ir_we(b_ir_we), .o_pc_we(b_pc_we),
        .o_pc_src(b_pc_src), .o_reg_we(b_reg_we), .o_reg_dst(b_reg_dst),
        .o_mem_to_reg(b_m2r), .o_illegal(b_illegal), .o_state(b_state),
        .o_retired(b_retired)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cyc_t e;
            ctl_t a, b;
            e = exp_q.pop_front();
            a = '{a_state, a_func, a_srca, a_srcb, a_iord, a_mem_re, a_mem_we,
                  a_ir_we, a_pc_we, a_pc_src, a_reg_we, a_reg_dst, a_m2r, a_illegal};
            b = '{b_state, b_func, b_srca, b_srcb, b_iord, b_mem_re, b_mem_we,
                  b_ir_we, b_pc_we, b_pc_src, b_reg_we, b_reg_dst, b_m2r, b_illegal};
            check("ctl", 64'(a), 64'(e.ctl));
            check("ctl_cnt4", 64'(b), 64'(e.ctl));
            check("retired", 64'(a_retired), 64'(e.retired));
            check("retired_cnt4", 64'(b_retired), 64'(e.retired % 16));
        end
    end

    // ---------------- reference model ----------------
    function automatic int r_func(logic [5:0] fn);
        case (fn)
            6'h20:   return 0;
            6'h22:   return 1;
            6'h24:   return 2;
            6'h25:   return 3;
            6'h26:   return 4;
            6'h2A:   return 5;
            default: return -1;
        endcase
    endfunction

    // A cycle whose memory-ready / zero inputs are don't-cares gets random ones.
    function automatic cyc_t mk(int st);
        cyc_t c;
        c.ctl       = '0;
        c.ctl.state = 4'(st);
        c.rst       = 1'b0;
        c.rdy       = 1'($urandom_range(0, 1));
        c.zero      = 1'($urandom_range(0, 1));
        c.retired   = model_ret;
        return c;
    endfunction

    task automatic add_fetch(int waits);
        cyc_t c;
        for (int w = 0; w <= waits; w++) begin
            c = mk(0);
            c.ctl.mem_re = 1'b1;
            c.ctl.srcb   = 2'b01;
            c.rdy        = (w == waits);
            c.ctl.ir_we  = c.rdy;
            c.ctl.pc_we  = c.rdy;
            trace.push_back(c);
        end
        c = mk(1);
        c.ctl.srcb = 2'b11;
        trace.push_back(c);
    endtask

    // Memory access phase: waits not-ready cycles then the acknowledge cycle.
    task automatic add_mem(int st, bit wr, int waits);
        cyc_t c;
        for (int w = 0; w <= waits; w++) begin
            c = mk(st);
            c.ctl.iord   = 1'b1;
            c.ctl.mem_re = !wr;
            c.ctl.mem_we = wr;
            c.rdy        = (w == waits);
            trace.push_back(c);
        end
    endtask

    task automatic issue(logic [31:0] ins);
        instr = ins;
        foreach (trace[i]) exp_q.push_back(trace[i]);
        foreach (trace[i]) begin
            rst       = trace[i].rst;
            mem_ready = trace[i].rdy;
            zero      = trace[i].zero;
            @(posedge clk);
            #1;
        end
        trace.delete();
    endtask

    // Expected trace of one complete instruction, from its encoding.
    task automatic run_instr(logic [31:0] ins, int wf, int wm, logic z);
        cyc_t c;
        logic [5:0] op;
        int f;
        bit done;
        op   = ins[31:26];
        f    = r_func(ins[5:0]);
        done = 1'b1;
        add_fetch(wf);
        if (op == 6'h00 && f >= 0) begin
            c = mk(6); c.ctl.srca = 1'b1; c.ctl.func = 11'(f); trace.push_back(c);
            c = mk(7); c.ctl.reg_we = 1'b1; c.ctl.reg_dst = 1'b1; trace.push_back(c);
        end else if (op == 6'h23 || op == 6'h2B) begin
            c = mk(2); c.ctl.srca = 1'b1; c.ctl.srcb = 2'b10; trace.push_back(c);
            if (op == 6'h23) begin
                add_mem(3, 1'b0, wm);
                c = mk(4); c.ctl.reg_we = 1'b1; c.ctl.mem_to_reg = 1'b1;
                trace.push_back(c);
            end else begin
                add_mem(5, 1'b1, wm);
            end
        end else if (op == 6'h04) begin
            c = mk(8); c.ctl.srca = 1'b1; c.ctl.func = 11'd1; c.ctl.pc_src = 2'b01;
            c.zero = z; c.ctl.pc_we = z; trace.push_back(c);
        end else if (op == 6'h08) begin
            c = mk(9); c.ctl.srca = 1'b1; c.ctl.srcb = 2'b10; trace.push_back(c);
            c = mk(12); c.ctl.reg_we = 1'b1; trace.push_back(c);
        end else if (op == 6'h02) begin
            c = mk(10); c.ctl.pc_src = 2'b10; c.ctl.pc_we = 1'b1; trace.push_back(c);
        end else begin
            c = mk(11); c.ctl.illegal = 1'b1; trace.push_back(c);
            done = 1'b0;
        end
        issue(ins);
        if (done) model_ret++;
    endtask

    // One cycle with reset high: state already FETCH, every enable forced low.
    task automatic reset_cycle();
        cyc_t c;
        c = mk(0);
        c.rst      = 1'b1;
        c.ctl.srcb = 2'b01;
        trace.push_back(c);
        issue(instr);
        model_ret = 0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0]  fn, op;
        logic [5:0]  legal_fn[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A};
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return {6'h00, r[25:6], legal_fn[$urandom_range(0, 5)]};
            1: begin
                do fn = 6'($urandom_range(0, 63)); while (r_func(fn) >= 0);
                return {6'h00, r[25:6], fn};
            end
            2: return {6'h23, r[25:0]};
            3: return {6'h2B, r[25:0]};
            4: return {6'h04, r[25:0]};
            5: return {6'h08, r[25:0]};
            6: return {6'h02, r[25:0]};
            default: begin
                do op = 6'($urandom_range(0, 63));
                while (op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02});
                return {op, r[25:0]};
            end
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc_t c;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_cycle();

        // sub: 0,1,6,7 then retired = 1
        run_instr(32'h012A4022, 0, 0, 1'b0);
        // lw with two stalls in FETCH and MEMRD: 9 cycles
        run_instr(32'h8D090004, 2, 2, 1'b0);
        // beq taken and not taken
        run_instr(32'h11090003, 0, 0, 1'b1);
        run_instr(32'h11090003, 0, 0, 1'b0);
        // illegal opcode and illegal funct
        run_instr(32'hFC000000, 0, 0, 1'b0);
        run_instr(32'h0000003F, 0, 0, 1'b0);
        run_instr(32'h08000010, 1, 0, 1'b0);

        // sw abandoned by reset while MEMWR waits on memory
        instr = 32'hAD090004;
        add_fetch(0);
        c = mk(2); c.ctl.srca = 1'b1; c.ctl.srcb = 2'b10; trace.push_back(c);
        c = mk(5); c.ctl.iord = 1'b1; c.ctl.mem_we = 1'b1; c.rdy = 1'b0;
        trace.push_back(c);
        c = mk(5); c.ctl.iord = 1'b1; c.rdy = 1'b0; c.rst = 1'b1;
        trace.push_back(c);
        issue(32'hAD090004);
        model_ret = 0;

        // 17 addi: narrow counter wraps to 1
        for (int i = 0; i < 17; i++) run_instr(32'h21290001, 0, 0, 1'b0);
        run_instr(32'h02000000, 0, 0, 1'b0);

        // randomized mix with random memory waits
        for (int i = 0; i < 120; i++)
            run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)));

        @(negedge clk);
        #1;
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_alu_ctrl.md
Name: mc_alu_ctrl

Overview:
- Multi-cycle control FSM for the MIPS datapath; it is the driving end of the ALU interface.
- Decodes the held instruction register and sequences every instruction through fetch, decode, execute, memory and writeback.
- Per cycle it drives the ALU function code and operand-select lines, consumes the ALU zero flag for branches, and drives all datapath write enables and memory strobes.

Parameters:
- FUNC_SIZE, 11, width of o_func; must match the ALU function input.
- CNT_SIZE, 32, width of the retired-instruction counter.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_instr  in  32  instruction register contents; stable from DECODE onward.
- i_mem_ready  in  1  memory acknowledge for the current read or write access.
- i_zero  in  1  ALU zero flag, same cycle as o_func.
- o_func  out  FUNC_SIZE  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT.
- o_srca_sel  out  1  ALU A source: 0 = PC, 1 = register rs.
- o_srcb_sel  out  2  ALU B source: 00 = rt, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- o_iord  out  1  memory address source: 0 = PC, 1 = ALUOut.
- o_mem_re  out  1  memory read strobe.
- o_mem_we  out  1  memory write strobe.
- o_ir_we  out  1  instruction register load.
- o_pc_we  out  1  PC load.
- o_pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- o_reg_we  out  1  register file write.
- o_reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- o_mem_to_reg  out  1  writeback data: 0 = ALUOut, 1 = memory data.
- o_illegal  out  1  one-cycle pulse on an unsupported instruction.
- o_state  out  4  current state encoding, for debug.
- o_retired  out  CNT_SIZE  count of completed instructions.

Behaviour:
- Reset: i_rst is sampled on the clock edge. The edge with i_rst high sets state to FETCH and o_retired to 0. This applies mid-instruction: the in-flight instruction is abandoned and not counted.
- While i_rst is high, all write enables and strobes are forced to 0: o_mem_we, o_ir_we, o_pc_we, o_reg_we, o_mem_re, o_illegal.
- Default values in every state unless listed: o_func = 0, all selects = 0, all enables = 0.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXE 6, ALUWB 7, BRANCH 8, ADDIEXE 9, JUMP 10, ILLEGAL 11, ADDIWB 12. Unused encodings go to FETCH.
- FETCH: o_mem_re = 1, srca = 0, srcb = 01, func ADD.
  - If i_mem_ready: o_ir_we = 1 and o_pc_we = 1 in the same cycle (combinational on i_mem_ready, pc_src 00), next state DECODE.
  - Otherwise hold in FETCH.
- DECODE: srca = 0, srcb = 11, func ADD (branch target into ALUOut). Next state by opcode i_instr[31:26]:
  - 0x00 -> RTEXE, only if funct i_instr[5:0] is in {0x20, 0x22, 0x24, 0x25, 0x26, 0x2A}; otherwise ILLEGAL.
  - 0x23 or 0x2B -> MEMADR.
  - 0x04 -> BRANCH.
  - 0x08 -> ADDIEXE.
  - 0x02 -> JUMP.
  - Anything else -> ILLEGAL.
- MEMADR: srca = 1, srcb = 10, ADD. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: o_iord = 1, o_mem_re = 1. Wait for i_mem_ready, then MEMWB.
- MEMWB: o_reg_we = 1, reg_dst 0, mem_to_reg 1. Next FETCH.
- MEMWR: o_iord = 1, o_mem_we = 1. Hold o_mem_we until i_mem_ready, then FETCH.
- RTEXE: srca = 1, srcb = 00. func from funct: 0x20 -> 0, 0x22 -> 1, 0x24 -> 2, 0x25 -> 3, 0x26 -> 4, 0x2A -> 5. Next ALUWB.
- ALUWB: o_reg_we = 1, reg_dst 1, mem_to_reg 0. Next FETCH.
- BRANCH: srca = 1, srcb = 00, SUB, pc_src 01, o_pc_we = i_zero. Next FETCH regardless of i_zero.
- ADDIEXE: srca = 1, srcb = 10, ADD. Next ADDIWB.
- ADDIWB: o_reg_we = 1, reg_dst 0, mem_to_reg 0. Next FETCH.
- JUMP: pc_src 10, o_pc_we = 1. Next FETCH.
- ILLEGAL: o_illegal = 1 for exactly one cycle. Next FETCH. o_retired is not incremented.
- o_retired increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP. It wraps modulo 2^CNT_SIZE.
- Latency with i_mem_ready always 1: R-type 4 cycles, addi 4, lw 5, sw 4, beq 3, j 3. Each wait cycle on memory adds 1.

Test Plan:
- Reset then R-type: release reset with i_mem_ready = 1 and i_instr = 0x012A4022 (sub). Expect state sequence 0, 1, 6, 7, 0; o_func = 1 in RTEXE; o_reg_we = 1 and o_reg_dst = 1 in ALUWB; o_retired = 1.
- lw with memory stalls: i_instr = 0x8D090004, i_mem_ready low for 2 cycles in both FETCH and MEMRD. Expect 9 total cycles; o_mem_to_reg = 1 with o_reg_we in MEMWB; o_ir_we pulses only on the ready cycle.
- beq: i_instr = 0x11090003, run once with i_zero = 1 and once with i_zero = 0. Expect o_pc_we = 1 with pc_src 01 only when zero is 1; both take 3 cycles and increment o_retired.
- Illegal opcode: i_instr = 0xFC000000, and R-type funct 0x3F. Expect ILLEGAL state for 1 cycle, o_illegal high for 1 cycle, o_retired unchanged, back to FETCH.
- Reset mid-instruction: assert i_rst in MEMWR while i_mem_ready = 0. Expect o_mem_we = 0 in that cycle, state 0 on the next edge, o_retired = 0.
- Counter wrap: with CNT_SIZE = 4, retire 17 addi instructions (0x21290001). Expect o_retired = 1.
